riscv_lsu: RTL and testbench
============================

# riscv_lsu

Load-store unit sitting between the core's execute stage and the data memory bus. It consumes the memory-access controls the instruction decoder issues (request, write enable, 3-bit size code) together with the ALU-computed address and rs2 data. It registers each access, drives a word-addressed byte-enable bus transaction, and stalls the core until the access completes. Loaded data is returned aligned and sign/zero-extended; misaligned accesses and bus timeouts are reported as faults.

## Interface
- TIMEOUT, 16'd256: max REQ cycles waiting for mem_ready_i; 0 disables the timeout
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- core_req_i  in  1  access request from the decoder (mem_req)
- core_we_i  in  1  1 = store, 0 = load
- core_size_i  in  3  0 B, 1 H, 2 W, 4 BU, 5 HU
- core_addr_i  in  32  byte address from the ALU
- core_wd_i  in  32  store data (rs2)
- core_rd_o  out  32  aligned, extended load data
- core_stall_o  out  1  hold the core's PC/pipeline
- core_fault_o  out  1  access fault, single cycle
- core_fault_cause_o  out  2  1 misaligned load, 2 misaligned store, 3 bus timeout
- mem_req_o  out  1  bus request
- mem_we_o  out  1  bus write
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  word address, bits [1:0] = 0
- mem_wd_o  out  32  lane-replicated write data
- mem_rd_i  in  32  bus read word
- mem_ready_i  in  1  bus completion, valid only while mem_req_o=1

## Operation
- FSM states: IDLE, REQ, DONE.
- Legality is checked in IDLE. Illegal cases:
  - H/HU with addr[0]=1
  - W with addr[1:0]≠0
  - size 3, 6 or 7
  - store with size 4 or 5
- IDLE, core_req_i=1, legal:
  - core_stall_o=1
  - register addr, size, we, be, wd
  - next state REQ
- IDLE, core_req_i=1, illegal:
  - core_fault_o=1; cause 1 for a load, 2 for a store
  - core_stall_o=0
  - stay in IDLE; no bus activity
- REQ:
  - mem_req_o=1 with the registered fields; core_stall_o=1
  - mem_ready_i=1: capture the formatted mem_rd_i into rd_q, next state DONE
  - otherwise stay in REQ and increment the wait counter
- DONE:
  - core_stall_o=0, mem_req_o=0, core_rd_o=rd_q
  - next state IDLE unconditionally
- Byte enables, off = addr[1:0]:
  - B: 4'b0001<<off
  - H: 4'b0011<<off
  - W: 4'b1111
  - loads: 4'b0000
- Write data:
  - B: byte replicated ×4
  - H: halfword replicated ×2
  - W: unchanged
- Read formatting:
  - B: byte lane off, sign-extended
  - BU: byte lane off, zero-extended
  - H: halfword lane addr[1], sign-extended
  - HU: halfword lane addr[1], zero-extended
  - W: whole word
- Timeout (TIMEOUT≠0): the wait counter clears on REQ entry. If it reaches TIMEOUT-1 without ready:
  - next state DONE with rd_q=0
  - in DONE: core_fault_o=1, cause 3
  - mem_ready_i arriving in the same cycle wins; no fault is raised
- core_addr_i, core_wd_i, core_size_i and core_we_i are ignored outside IDLE. Deasserting core_req_i in REQ does not abort the access.
- mem_ready_i is ignored in IDLE and DONE.

## Timing
- Reset values (rst_ni=0 at an edge): state IDLE, rd_q=0, counter=0, registered fields 0.
- While rst_ni=0, every output is 0 regardless of inputs, including the combinational core_stall_o and core_fault_o.
- Reset asserted mid-transaction abandons the access. mem_req_o is 0 from that cycle; no completion or fault is reported.
- Latency with ready in the first REQ cycle:
  - stall high at T (IDLE) and T+1 (REQ)
  - stall low at T+2 (DONE); core_rd_o valid at T+2
  - the core commits at the edge closing T+2
- Each extra wait cycle adds one cycle of latency.
- A new request is accepted at T+3 at the earliest (back in IDLE).
- A misaligned access costs 0 stall cycles; core_fault_o and cause are combinational in the same cycle.
- Bus outputs are registered and stable for the whole of REQ.

## Test plan
- LB at 0x1003, mem_rd_i=0x80FF_0000 ready in the first REQ cycle -> mem_addr_o=0x1000, mem_be_o=0000, core_rd_o=0xFFFF_FF80 in DONE, stall pattern 1,1,0.
- SH at 0x2002 with wd=0x1234_ABCD -> mem_we_o=1, mem_be_o=1100, mem_wd_o=0xABCD_ABCD.
- SB at 0x2001 with wd=0x0000_0077 -> mem_be_o=0010, mem_wd_o=0x7777_7777.
- LHU at 0x3002, ready after 3 wait cycles, mem_rd_i=0xBEEF_0000 -> stall high for 5 cycles, core_rd_o=0x0000_BEEF.
- LW at 0x4001 -> fault=1, cause=1, stall=0, mem_req_o never asserted. SH at 0x4003 -> cause=2.
- TIMEOUT=4, no ready -> 4 REQ cycles, then DONE with fault=1, cause=3, core_rd_o=0. Repeat with ready on the 4th REQ cycle -> no fault.
- Reset pulsed during REQ -> mem_req_o=0 from that cycle; the next request completes normally.

Source files
------------

// File: rtl/riscv_lsu_if.sv
// Data-memory bus between the load-store unit and the memory.
// Member names keep the LSU's point of view (_o driven by the LSU, _i driven by memory).
interface riscv_lsu_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    // LSU side: issues word-addressed byte-enable transactions
    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_be_o,
        output mem_addr_o,
        output mem_wd_o,
        input  mem_rd_i,
        input  mem_ready_i
    );

    // Memory side: answers with read data and a completion strobe
    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_be_o,
        input  mem_addr_o,
        input  mem_wd_o,
        output mem_rd_i,
        output mem_ready_i
    );
endinterface

// File: rtl/riscv_lsu.sv
// Load-store unit: registers a core access, runs one bus transaction,
// stalls the core until completion and returns aligned/extended load data.
module riscv_lsu #(
    parameter logic [15:0] TIMEOUT = 16'd256
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               core_req_i,
    input  logic               core_we_i,
    input  logic [2:0]         core_size_i,
    input  logic [31:0]        core_addr_i,
    input  logic [31:0]        core_wd_i,
    output logic [31:0]        core_rd_o,
    output logic               core_stall_o,
    output logic               core_fault_o,
    output logic [1:0]         core_fault_cause_o,
    riscv_lsu_if.master        bus
);

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned BEW = 4;
    localparam int unsigned CW  = 16;

    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_LD_MIS  = 2'd1;
    localparam logic [1:0] CAUSE_ST_MIS  = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    localparam bit            TMO_EN   = (TIMEOUT != 16'd0);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 16'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q;
    logic [AW-1:0]   addr_q;
    logic [2:0]      size_q;
    logic            we_q;
    logic [BEW-1:0]  be_q;
    logic [DW-1:0]   wd_q;
    logic [DW-1:0]   rd_q;
    logic [CW-1:0]   cnt_q;
    logic            tmo_q;
    logic            req_q;

    logic            legal_c;
    logic [BEW-1:0]  be_c;
    logic [DW-1:0]   wd_c;
    logic [7:0]      byte_c;
    logic [15:0]     half_c;
    logic [DW-1:0]   fmt_c;
    logic            stall_c;
    logic            fault_c;
    logic [1:0]      cause_c;

    // Alignment / size-code legality of the access offered by the core
    always_comb begin
        legal_c = 1'b0;
        case (core_size_i)
            SZ_B:    legal_c = 1'b1;
            SZ_BU:   legal_c = !core_we_i;
            SZ_H:    legal_c = !core_addr_i[0];
            SZ_HU:   legal_c = !core_addr_i[0] && !core_we_i;
            SZ_W:    legal_c = (core_addr_i[1:0] == 2'b00);
            default: legal_c = 1'b0;
        endcase
    end

    // Store byte enables and lane-replicated write data
    always_comb begin
        be_c = '0;
        wd_c = core_wd_i;
        case (core_size_i)
            SZ_B, SZ_BU: begin
                be_c = BEW'(4'b0001 << core_addr_i[1:0]);
                wd_c = {4{core_wd_i[7:0]}};
            end
            SZ_H, SZ_HU: begin
                be_c = BEW'(4'b0011 << core_addr_i[1:0]);
                wd_c = {2{core_wd_i[15:0]}};
            end
            SZ_W:    be_c = 4'b1111;
            default: be_c = '0;
        endcase
        if (!core_we_i) begin
            be_c = '0;
        end
    end

    // Pick the addressed lane of the returned word and extend it
    always_comb begin
        byte_c = 8'h00;
        case (addr_q[1:0])
            2'd0:    byte_c = bus.mem_rd_i[7:0];
            2'd1:    byte_c = bus.mem_rd_i[15:8];
            2'd2:    byte_c = bus.mem_rd_i[23:16];
            default: byte_c = bus.mem_rd_i[31:24];
        endcase
        half_c = addr_q[1] ? bus.mem_rd_i[31:16] : bus.mem_rd_i[15:0];
        case (size_q)
            SZ_B:    fmt_c = {{24{byte_c[7]}}, byte_c};
            SZ_BU:   fmt_c = {24'h000000, byte_c};
            SZ_H:    fmt_c = {{16{half_c[15]}}, half_c};
            SZ_HU:   fmt_c = {16'h0000, half_c};
            default: fmt_c = bus.mem_rd_i;
        endcase
    end

    // Access FSM: capture in IDLE, wait for ready (or timeout) in REQ, report in DONE
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wd_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (core_req_i && legal_c) begin
                        addr_q  <= core_addr_i;
                        size_q  <= core_size_i;
                        we_q    <= core_we_i;
                        be_q    <= be_c;
                        wd_q    <= wd_c;
                        cnt_q   <= '0;
                        tmo_q   <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.mem_ready_i) begin
                        rd_q    <= fmt_c;
                        req_q   <= 1'b0;
                        state_q <= ST_DONE;
                    end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
                        rd_q    <= '0;
                        tmo_q   <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    tmo_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall and fault are combinational so a misaligned access costs no cycle
    always_comb begin
        stall_c = 1'b0;
        fault_c = 1'b0;
        cause_c = CAUSE_NONE;
        case (state_q)
            ST_IDLE: begin
                if (core_req_i) begin
                    stall_c = legal_c;
                    if (!legal_c) begin
                        fault_c = 1'b1;
                        cause_c = core_we_i ? CAUSE_ST_MIS : CAUSE_LD_MIS;
                    end
                end
            end
            ST_REQ:  stall_c = 1'b1;
            ST_DONE: begin
                if (tmo_q) begin
                    fault_c = 1'b1;
                    cause_c = CAUSE_TIMEOUT;
                end
            end
            default: stall_c = 1'b0;
        endcase
    end

    // Every output is forced low while reset is held, even before the reset edge
    assign core_stall_o       = rst_ni & stall_c;
    assign core_fault_o       = rst_ni & fault_c;
    assign core_fault_cause_o = rst_ni ? cause_c : CAUSE_NONE;
    assign core_rd_o          = rst_ni ? rd_q : '0;

    assign bus.mem_req_o  = rst_ni & req_q;
    assign bus.mem_we_o   = rst_ni & we_q;
    assign bus.mem_be_o   = rst_ni ? be_q : '0;
    assign bus.mem_addr_o = rst_ni ? {addr_q[AW-1:2], 2'b00} : '0;
    assign bus.mem_wd_o   = rst_ni ? wd_q : '0;

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: directed vector table, reset corner sequences and
// randomized accesses checked against a byte-lane reference model.
module tb_riscv_lsu;

    localparam int TMO = 4;

    logic        clk_i;
    logic        rst_ni;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_fault_o;
    logic [1:0]  core_fault_cause_o;

    riscv_lsu_if bus_if ();

    riscv_lsu #(.TIMEOUT(16'(TMO))) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .core_req_i         (core_req_i),
        .core_we_i          (core_we_i),
        .core_size_i        (core_size_i),
        .core_addr_i        (core_addr_i),
        .core_wd_i          (core_wd_i),
        .core_rd_o          (core_rd_o),
        .core_stall_o       (core_stall_o),
        .core_fault_o       (core_fault_o),
        .core_fault_cause_o (core_fault_cause_o),
        .bus                (bus_if)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdw;
        int          waits;
        logic        legal;
        logic [3:0]  be;
        logic [31:0] bwd;
        logic [31:0] rd;
        logic [1:0]  cause;
        int          stalls;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] s);
        case (s)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic m_legal(input logic we, input logic [2:0] s, input logic [31:0] a);
        int n = nbytes(s);
        if (n == 0) return 1'b0;
        if (we && s >= 3'd4) return 1'b0;
        return (int'(a[1:0]) % n) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic we, input logic [2:0] s, input logic [31:0] a);
        logic [3:0] b = 4'b0000;
        int n = nbytes(s);
        if (!we) return 4'b0000;
        for (int i = 0; i < n; i++) begin
            if (int'(a[1:0]) + i < 4) b[int'(a[1:0]) + i] = 1'b1;
        end
        return b;
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] s, input logic [31:0] d);
        logic [31:0] r = 32'h0;
        int n = nbytes(s);
        if (n == 0) return d;
        for (int l = 0; l < 4; l++) r[8*l +: 8] = d[8*(l % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_rd(input logic [2:0] s, input logic [31:0] a, input logic [31:0] w);
        int n = nbytes(s);
        logic [31:0] v;
        v = w >> (8 * int'(a[1:0]));
        if (n == 1) v = v & 32'h0000_00FF;
        else if (n == 2) v = v & 32'h0000_FFFF;
        if (s == 3'd0 && v >= 32'd128)    v = v - 32'd256;
        if (s == 3'd1 && v >= 32'h8000)   v = v - 32'h1_0000;
        return v;
    endfunction

    function automatic vec_t mk(input string name, input logic we, input logic [2:0] size,
                                input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdw,
                                input int waits, input logic legal, input logic [3:0] be,
                                input logic [31:0] bwd, input logic [31:0] rd, input logic [1:0] cause,
                                input int stalls);
        vec_t v;
        v.name = name; v.we = we; v.size = size; v.addr = addr; v.wd = wd; v.rdw = rdw;
        v.waits = waits; v.legal = legal; v.be = be; v.bwd = bwd; v.rd = rd;
        v.cause = cause; v.stalls = stalls;
        return v;
    endfunction

    function automatic vec_t mk_rand(input int idx);
        vec_t v;
        logic timed;
        v.name  = $sformatf("rnd%0d", idx);
        v.we    = 1'($urandom_range(0, 1));
        v.size  = 3'($urandom_range(0, 7));
        v.addr  = $urandom;
        v.wd    = $urandom;
        v.rdw   = $urandom;
        v.waits = $urandom_range(0, TMO + 1);
        v.legal = m_legal(v.we, v.size, v.addr);
        timed   = (v.waits >= TMO);
        v.be    = m_be(v.we, v.size, v.addr);
        v.bwd   = m_wd(v.size, v.wd);
        v.rd    = timed ? 32'h0 : m_rd(v.size, v.addr, v.rdw);
        if (!v.legal)  v.cause = v.we ? 2'd2 : 2'd1;
        else if (timed) v.cause = 2'd3;
        else           v.cause = 2'd0;
        if (!v.legal)  v.stalls = 0;
        else           v.stalls = 1 + (timed ? TMO : v.waits + 1);
        return v;
    endfunction

    // ---------------- one complete access ----------------
    task automatic run_vec(input vec_t v);
        int   stalls;
        logic timed;
        logic fin;
        timed = v.legal && (v.waits >= TMO);
        core_req_i  = 1'b1;
        core_we_i   = v.we;
        core_size_i = v.size;
        core_addr_i = v.addr;
        core_wd_i   = v.wd;
        bus_if.mem_ready_i = 1'($urandom_range(0, 1));
        bus_if.mem_rd_i    = $urandom;
        #1;
        stalls = int'(core_stall_o);
        chk({v.name, " stall_idle"}, 32'(core_stall_o), 32'(v.legal));
        chk({v.name, " fault_idle"}, 32'(core_fault_o), 32'(!v.legal));
        if (!v.legal) chk({v.name, " cause_idle"}, 32'(core_fault_cause_o), 32'(v.cause));
        chk({v.name, " req_idle"}, 32'(bus_if.mem_req_o), 32'h0);
        tick();
        core_req_i  = 1'b0;
        core_we_i   = 1'($urandom_range(0, 1));
        core_size_i = 3'($urandom_range(0, 7));
        core_addr_i = $urandom;
        core_wd_i   = $urandom;
        if (!v.legal) begin
            bus_if.mem_ready_i = 1'b0;
            #1;
            chk({v.name, " req_after_fault"}, 32'(bus_if.mem_req_o), 32'h0);
            chk({v.name, " stall_after_fault"}, 32'(core_stall_o), 32'h0);
            chk({v.name, " stall_count"}, 32'(stalls), 32'(v.stalls));
            return;
        end
        fin = 1'b0;
        for (int w = 0; w < TMO && !fin; w++) begin
            bus_if.mem_ready_i = (w == v.waits);
            bus_if.mem_rd_i    = (w == v.waits) ? v.rdw : $urandom;
            #1;
            stalls += int'(core_stall_o);
            chk({v.name, " mem_req"},  32'(bus_if.mem_req_o), 32'h1);
            chk({v.name, " mem_addr"}, bus_if.mem_addr_o, {v.addr[31:2], 2'b00});
            chk({v.name, " mem_we"},   32'(bus_if.mem_we_o), 32'(v.we));
            chk({v.name, " mem_be"},   32'(bus_if.mem_be_o), 32'(v.be));
            if (v.we) chk({v.name, " mem_wd"}, bus_if.mem_wd_o, v.bwd);
            chk({v.name, " fault_req"}, 32'(core_fault_o), 32'h0);
            if (w == v.waits || w == TMO - 1) fin = 1'b1;
            tick();
        end
        bus_if.mem_ready_i = 1'($urandom_range(0, 1));
        bus_if.mem_rd_i    = $urandom;
        #1;
        stalls += int'(core_stall_o);
        chk({v.name, " stall_done"}, 32'(core_stall_o), 32'h0);
        chk({v.name, " req_done"},   32'(bus_if.mem_req_o), 32'h0);
        chk({v.name, " fault_done"}, 32'(core_fault_o), 32'(timed));
        if (timed) chk({v.name, " cause_done"}, 32'(core_fault_cause_o), 32'h3);
        if (!v.we || timed) chk({v.name, " rd_done"}, core_rd_o, v.rd);
        chk({v.name, " stall_count"}, 32'(stalls), 32'(v.stalls));
        tick();
        bus_if.mem_ready_i = 1'b0;
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = mk("lb_1003",   1'b0, 3'd0, 32'h0000_1003, 32'h0,         32'h80FF_0000, 0, 1'b1, 4'b0000, 32'h0,         32'hFFFF_FF80, 2'd0, 2);
        vecs[1]  = mk("sh_2002",   1'b1, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 32'h0,         1, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0,         2'd0, 3);
        vecs[2]  = mk("sb_2001",   1'b1, 3'd0, 32'h0000_2001, 32'h0000_0077, 32'h0,         0, 1'b1, 4'b0010, 32'h7777_7777, 32'h0,         2'd0, 2);
        vecs[3]  = mk("lhu_3002",  1'b0, 3'd5, 32'h0000_3002, 32'h0,         32'hBEEF_0000, 3, 1'b1, 4'b0000, 32'h0,         32'h0000_BEEF, 2'd0, 5);
        vecs[4]  = mk("lw_mis",    1'b0, 3'd2, 32'h0000_4001, 32'h0,         32'h0,         0, 1'b0, 4'b0000, 32'h0,         32'h0,         2'd1, 0);
        vecs[5]  = mk("sh_mis",    1'b1, 3'd1, 32'h0000_4003, 32'h0,         32'h0,         0, 1'b0, 4'b0000, 32'h0,         32'h0,         2'd2, 0);
        vecs[6]  = mk("lw_tmo",    1'b0, 3'd2, 32'h0000_5000, 32'h0,         32'h1111_2222, 9, 1'b1, 4'b0000, 32'h0,         32'h0,         2'd3, 5);
        vecs[7]  = mk("lw_last",   1'b0, 3'd2, 32'h0000_5004, 32'h0,         32'hCAFE_F00D, 3, 1'b1, 4'b0000, 32'h0,         32'hCAFE_F00D, 2'd0, 5);
        vecs[8]  = mk("lh_6002",   1'b0, 3'd1, 32'h0000_6002, 32'h0,         32'h8001_1234, 0, 1'b1, 4'b0000, 32'h0,         32'hFFFF_8001, 2'd0, 2);
        vecs[9]  = mk("lbu_6001",  1'b0, 3'd4, 32'h0000_6001, 32'h0,         32'h0000_9A00, 2, 1'b1, 4'b0000, 32'h0,         32'h0000_009A, 2'd0, 4);
        vecs[10] = mk("ld_sz3",    1'b0, 3'd3, 32'h0000_7000, 32'h0,         32'h0,         0, 1'b0, 4'b0000, 32'h0,         32'h0,         2'd1, 0);
        vecs[11] = mk("st_sz4",    1'b1, 3'd4, 32'h0000_7000, 32'h0,         32'h0,         0, 1'b0, 4'b0000, 32'h0,         32'h0,         2'd2, 0);
        vecs[12] = mk("sw_8000",   1'b1, 3'd2, 32'h0000_8000, 32'hDEAD_BEEF, 32'h0,         0, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0,         2'd0, 2);
        vecs[13] = mk("lb_1000",   1'b0, 3'd0, 32'h0000_1000, 32'h0,         32'h0000_007F, 1, 1'b1, 4'b0000, 32'h0,         32'h0000_007F, 2'd0, 3);

        // Reset held with a live, legal request on the inputs: everything stays low
        rst_ni = 1'b0;
        core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = 3'd2;
        core_addr_i = 32'h0000_0100; core_wd_i = 32'hFFFF_FFFF;
        bus_if.mem_ready_i = 1'b1; bus_if.mem_rd_i = 32'hFFFF_FFFF;
        #2;
        chk("rst_stall_pre_edge", 32'(core_stall_o), 32'h0);
        chk("rst_fault_pre_edge", 32'(core_fault_o), 32'h0);
        tick(); tick();
        chk("rst_stall",  32'(core_stall_o), 32'h0);
        chk("rst_fault",  32'(core_fault_o), 32'h0);
        chk("rst_cause",  32'(core_fault_cause_o), 32'h0);
        chk("rst_rd",     core_rd_o, 32'h0);
        chk("rst_req",    32'(bus_if.mem_req_o), 32'h0);
        chk("rst_we",     32'(bus_if.mem_we_o), 32'h0);
        chk("rst_be",     32'(bus_if.mem_be_o), 32'h0);
        chk("rst_addr",   bus_if.mem_addr_o, 32'h0);
        chk("rst_wd",     bus_if.mem_wd_o, 32'h0);
        core_req_i = 1'b0;
        bus_if.mem_ready_i = 1'b0;
        rst_ni = 1'b1;
        tick();

        // Directed vector table
        for (int i = 0; i < 14; i++) run_vec(vecs[i]);

        // Reset pulsed while the bus request is outstanding
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2;
        core_addr_i = 32'h0000_9000; core_wd_i = 32'h0;
        bus_if.mem_ready_i = 1'b0;
        tick();
        core_req_i = 1'b0;
        #1;
        chk("mid_rst_req_before", 32'(bus_if.mem_req_o), 32'h1);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_req_now",   32'(bus_if.mem_req_o), 32'h0);
        chk("mid_rst_stall_now", 32'(core_stall_o), 32'h0);
        tick();
        bus_if.mem_ready_i = 1'b1;
        #1;
        chk("mid_rst_req_edge",   32'(bus_if.mem_req_o), 32'h0);
        chk("mid_rst_fault_edge", 32'(core_fault_o), 32'h0);
        rst_ni = 1'b1;
        bus_if.mem_ready_i = 1'b0;
        tick();
        chk("post_rst_req",   32'(bus_if.mem_req_o), 32'h0);
        chk("post_rst_stall", 32'(core_stall_o), 32'h0);
        chk("post_rst_fault", 32'(core_fault_o), 32'h0);
        run_vec(vecs[0]);

        // Randomized accesses with idle gaps where ready is noise
        for (int r = 0; r < 200; r++) begin
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                core_req_i = 1'b0;
                bus_if.mem_ready_i = 1'($urandom_range(0, 1));
                bus_if.mem_rd_i = $urandom;
                #1;
                chk("gap_req",   32'(bus_if.mem_req_o), 32'h0);
                chk("gap_stall", 32'(core_stall_o), 32'h0);
                tick();
            end
            run_vec(mk_rand(r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
